// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: control-word bit positions,
// destination-register field, high-half target register and FSM states.
package wb_stage_pkg;

    localparam int unsigned REG_WRITE  = 0;
    localparam int unsigned MEM_TO_REG = 1;
    localparam int unsigned WIDE       = 2;

    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;

    localparam logic [3:0] HI_REG = 4'h0;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_retire_counter.sv
// 16-bit retirement counter: wraps at 16'hFFFF, synchronous clear wins over enable.
module wb_retire_counter (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, drives the register-file
// write port and forwarding path, and sequences the R0 write of wide results.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [15:0] write_back_ctrl_sgnl_out,
    input  logic [15:0] alu_result_bottom_half_out,
    input  logic [15:0] alu_result_top_half_out,
    input  logic [15:0] memory_data_out,
    input  logic [15:0] inst_buff_out,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [15:0] fwd_data,
    output logic        wb_stall,
    output logic [15:0] retired_count
);

    wb_state_e   r_state;
    logic [15:0] r_hi_hold;
    logic        r_we;
    logic [3:0]  r_waddr;
    logic [15:0] r_wdata;
    logic        r_stall;

    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_wide;
    logic [3:0]  w_rd;
    logic [15:0] w_lo_data;
    logic        w_retire;
    logic        w_unused_bits;

    assign w_reg_write  = write_back_ctrl_sgnl_out[REG_WRITE];
    assign w_mem_to_reg = write_back_ctrl_sgnl_out[MEM_TO_REG];
    assign w_wide       = write_back_ctrl_sgnl_out[WIDE];
    assign w_rd         = inst_buff_out[RD_MSB:RD_LSB];
    assign w_unused_bits = ^{write_back_ctrl_sgnl_out[15:3],
                             inst_buff_out[15:12], inst_buff_out[7:0]};

    // A wide result always takes its low half from the ALU.
    assign w_lo_data = (w_mem_to_reg && !w_wide) ? memory_data_out
                                                 : alu_result_bottom_half_out;

    // Count once per instruction: narrow writes in S_LO, wide ones on the R0 write.
    assign w_retire = !halt && !rst &&
                      ((r_state == S_HI) ||
                       (r_state == S_LO && w_reg_write && !w_wide));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LO;
            r_hi_hold <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_stall   <= 1'b0;
        end else if (halt) begin
            r_we <= 1'b0;
        end else begin
            case (r_state)
                S_LO: begin
                    r_stall <= 1'b0;
                    if (w_reg_write) begin
                        r_we    <= 1'b1;
                        r_waddr <= w_rd;
                        r_wdata <= w_lo_data;
                        if (w_wide) begin
                            r_hi_hold <= alu_result_top_half_out;
                            r_stall   <= 1'b1;
                            r_state   <= S_HI;
                        end
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                S_HI: begin
                    r_we    <= 1'b1;
                    r_waddr <= HI_REG;
                    r_wdata <= r_hi_hold;
                    r_stall <= 1'b0;
                    r_state <= S_LO;
                end
                default: begin
                    r_state <= S_LO;
                end
            endcase
        end
    end

    wb_retire_counter u_retire_counter (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_en    (w_retire),
        .o_count (retired_count)
    );

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign fwd_valid = r_we;
    assign fwd_addr  = r_waddr;
    assign fwd_data  = r_wdata;
    assign wb_stall  = r_stall;

endmodule
